// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and helpers for the 7-segment scan driver
package seg_pkg;

    // All segments and all anodes are active-low, so all-ones means dark.
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low hex patterns with dp off, indexed by nibble value (entry 15 listed first).
    localparam logic [15:0][7:0] HEX_PAT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Index of the highest nonzero nibble; 0 for an all-zero word.
    function automatic logic [2:0] msd_of(input logic [31:0] w);
        logic [2:0] m;
        m = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w[4*i +: 4] != 4'h0) m = 3'(i);
        end
        return m;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational nibble to active-low 7-segment pattern
// Ports: nib (4-bit hex value in), seg (7-bit active-low g..a out)
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_PAT[nib][6:0];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - eight-digit multiplexed 7-segment scanner with LZ blanking and halt blink
// Ports: clk_fast (clock), RST (async active-low reset), disp_data (32-bit word to show),
//        halt (CPU halted, blinks dp), frame_end (pulse when disp_data is latched),
//        SEG (active-low segments, [7]=dp), AN (active-low anodes, AN[0] = rightmost)
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 12500,
    parameter int GUARD_CYC    = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int BLANK_LZ     = 1
) (
    input  logic        clk_fast,
    input  logic        RST,
    input  logic [31:0] disp_data,
    input  logic        halt,
    output logic        frame_end,
    output logic [7:0]  SEG,
    output logic [7:0]  AN
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_GUARD = PW'(GUARD_CYC);
    localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic [FW-1:0] fcnt;
    logic          blink;
    logic [31:0]   shadow;

    logic          slot_tick;
    logic          frame_tick;
    logic [3:0]    nib;
    logic [6:0]    seg_pat;
    logic          blanked;

    assign slot_tick  = (pcnt == P_LAST);
    // Last slot of the frame: the only moment the shadow word may change, so no tearing.
    assign frame_tick = slot_tick && (idx == 3'd7);
    assign nib        = shadow[{idx, 2'b00} +: 4];
    assign blanked    = (BLANK_LZ != 0) && (idx > msd_of(shadow));

    hex7seg u_hex7seg (
        .nib (nib),
        .seg (seg_pat)
    );

    always_ff @(posedge clk_fast or negedge RST) begin
        if (!RST) begin
            pcnt      <= '0;
            idx       <= 3'd0;
            fcnt      <= '0;
            blink     <= 1'b0;
            shadow    <= 32'h0;
            frame_end <= 1'b0;
            SEG       <= SEG_OFF;
            AN        <= AN_OFF;
        end else begin
            pcnt      <= slot_tick ? '0 : pcnt + 1'b1;
            frame_end <= frame_tick;

            if (slot_tick) idx <= idx + 3'd1;
            if (frame_tick) shadow <= disp_data;

            // Blink phase only runs while halted; every halt episode starts dp-off.
            if (!halt) begin
                fcnt  <= '0;
                blink <= 1'b0;
            end else if (frame_tick) begin
                if (fcnt == F_LAST) begin
                    fcnt  <= '0;
                    blink <= ~blink;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end

            // Anodes stay dark for the first GUARD_CYC cycles of each slot to hide segment switching.
            AN  <= (pcnt < P_GUARD) ? AN_OFF : ~(8'b1 << idx);
            SEG <= {~(halt & blink), blanked ? 7'h7F : seg_pat};
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

    localparam int SD    = 8;
    localparam int GC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 8 * SD;

    logic        clk_fast = 1'b0;
    logic        RST;
    logic [31:0] disp_data;
    logic        halt;
    logic        fe_a, fe_b;
    logic [7:0]  seg_a, an_a, seg_b, an_b;

    always #5 clk_fast = ~clk_fast;

    seg_scan_driver #(.SCAN_DIV(SD), .GUARD_CYC(GC), .BLINK_FRAMES(BF), .BLANK_LZ(1)) u_dut_lz (
        .clk_fast (clk_fast), .RST (RST), .disp_data (disp_data), .halt (halt),
        .frame_end (fe_a), .SEG (seg_a), .AN (an_a)
    );

    seg_scan_driver #(.SCAN_DIV(SD), .GUARD_CYC(GC), .BLINK_FRAMES(BF), .BLANK_LZ(0)) u_dut_all (
        .clk_fast (clk_fast), .RST (RST), .disp_data (disp_data), .halt (halt),
        .frame_end (fe_b), .SEG (seg_b), .AN (an_b)
    );

    int vectors = 0;
    int errors  = 0;

    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference state: cycles since reset release, displayed word, frames spent halted.
    int          k;
    logic [31:0] sh_m;
    int          n_m;
    logic [7:0]  e_seg_a, e_seg_b, e_an;
    logic        e_fe;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic model_reset();
        k    = 0;
        sh_m = 32'h0;
        n_m  = 0;
    endtask

    // Expected outputs after the clock edge that sees inputs d/h, then advance the model.
    task automatic model_edge(input logic [31:0] d, input logic h);
        int         pc;
        int         ix;
        int         msd;
        logic [3:0] nb;
        logic       dp;
        pc  = k % SD;
        ix  = (k / SD) % 8;
        msd = 0;
        for (int i = 0; i < 8; i++) if (sh_m[4*i +: 4] != 4'h0) msd = i;
        nb  = sh_m[4*ix +: 4];
        dp  = !(h && ((n_m / BF) % 2 == 1));
        e_an    = (pc < GC) ? 8'hFF : ~(8'd1 << ix);
        e_seg_b = {dp, hex_tbl[nb][6:0]};
        e_seg_a = (ix > msd) ? {dp, 7'h7F} : e_seg_b;
        e_fe    = (k % FRAME == FRAME - 1);
        if (e_fe) sh_m = d;
        if (!h) n_m = 0;
        else if (e_fe) n_m++;
        k++;
    endtask

    task automatic step(input logic [31:0] d, input logic h);
        disp_data = d;
        halt      = h;
        @(posedge clk_fast);
        model_edge(d, h);
        @(negedge clk_fast);
        check("lz_seg", seg_a, e_seg_a);
        check("lz_an", an_a, e_an);
        check("lz_fe", fe_a, e_fe);
        check("all_seg", seg_b, e_seg_b);
        check("all_an", an_b, e_an);
        check("all_fe", fe_b, e_fe);
    endtask

    task automatic check_off(input string tag);
        check({tag, "_seg_a"}, seg_a, 8'hFF);
        check({tag, "_an_a"}, an_a, 8'hFF);
        check({tag, "_fe_a"}, fe_a, 1'b0);
        check({tag, "_seg_b"}, seg_b, 8'hFF);
        check({tag, "_an_b"}, an_b, 8'hFF);
        check({tag, "_fe_b"}, fe_b, 1'b0);
    endtask

    // Asynchronous reset between edges: outputs must go dark without a clock.
    task automatic async_reset(input string tag);
        #2 RST = 1'b0;
        #1 check_off(tag);
        @(negedge clk_fast);
        RST = 1'b1;
        model_reset();
    endtask

    logic [31:0] rd;
    logic        rh;

    initial begin
        RST       = 1'b0;
        disp_data = 32'h12345678;
        halt      = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_fast);
        check_off("reset");
        RST = 1'b1;

        repeat (FRAME) step(32'h12345678, 1'b0);
        repeat (FRAME) step(32'h0000ABCD, 1'b0);
        repeat (3 * SD) step(32'h0000ABCD, 1'b0);
        repeat (5 * SD + FRAME) step(32'hFFFFFFFF, 1'b0);
        repeat (2 * FRAME) step(32'h00000007, 1'b0);
        repeat (9 * FRAME + 13) step(32'h00000007, 1'b1);
        repeat (20) step(32'h00000007, 1'b0);
        repeat (5 * FRAME) step(32'h00F0000A, 1'b1);

        while (k % FRAME != 6 * SD + 6) step(32'h00F0000A, 1'b1);
        async_reset("mid_reset");
        repeat (FRAME + 5) step(32'h00F0000A, 1'b0);

        rd = 32'h0;
        rh = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) begin
                rd = $urandom;
                if ($urandom_range(0, 1) == 0) rd = rd >> (4 * $urandom_range(0, 8));
            end
            if ($urandom_range(0, 99) == 0) rh = ~rh;
            if ($urandom_range(0, 499) == 0) async_reset("rand_reset");
            step(rd, rh);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
